// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART transmitter
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead byte FIFO with wrap-bit pointers
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr, rd;
   logic do_push, do_pop;
   assign level = wr - rd;
   assign full = level == (AW+1)'(DEPTH);
   assign empty = level == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign head = mem[rd[AW-1:0]];
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serialiser with local bit timer, byte FIFO and line-idle detector
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 4,
   parameter int IDLE_BITS    = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        tx,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] tx_level,
   output logic                        tx_idle
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IL = IDLE_BITS * CLKS_PER_BIT;
   localparam int IW = $clog2(IL + 1);
   uart_tx_state_t state;
   logic [CW-1:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift, head;
   logic [IW-1:0] idle_cnt;
   logic full, empty, push, pop, period_end;
   assign tx_ready = !full;
   assign push = tx_valid && tx_ready;
   assign period_end = cnt == CW'(CLKS_PER_BIT - 1);
   // the head is popped when a frame can start: from IDLE, or straight out of a finishing stop bit
   assign pop = !empty && (state == IDLE || (state == STOP && period_end));
   assign tx_busy = state != IDLE;
   assign tx_idle = idle_cnt == IW'(IL);
   uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .din(tx_data),
      .head(head), .full(full), .empty(empty), .level(tx_level)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         shift <= '0;
         tx <= 1'b1;
      end else begin
         cnt <= (state == IDLE || period_end) ? '0 : cnt + 1'b1;
         case (state)
            IDLE: if (pop) begin
               shift <= head;
               idx <= '0;
               tx <= 1'b0;
               state <= START;
            end
            START: if (period_end) begin
               tx <= shift[0];
               state <= DATA;
            end
            DATA: if (period_end) begin
               shift <= shift >> 1;
               idx <= idx + 1'b1;
               tx <= (idx == 3'(DATA_BITS - 1)) ? 1'b1 : shift[1];
               state <= (idx == 3'(DATA_BITS - 1)) ? STOP : DATA;
            end
            STOP: if (period_end) begin
               if (pop) begin
                  shift <= head;
                  idx <= '0;
                  tx <= 1'b0;
                  state <= START;
               end else state <= IDLE;
            end
         endcase
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) idle_cnt <= '0;
      else idle_cnt <= (push || state != IDLE || !empty) ? '0 : (tx_idle ? idle_cnt : idle_cnt + 1'b1);
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx with a line-decoding monitor
module tb_uart_tx;
   localparam int CPB = 16;
   logic clk = 0, reset = 0, tx_valid = 0;
   logic [7:0] tx_data = 0;
   logic tx_ready, tx, tx_busy, tx_idle;
   logic [2:0] tx_level;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .IDLE_BITS(16)) dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx(tx), .tx_busy(tx_busy), .tx_level(tx_level), .tx_idle(tx_idle)
   );
   // decodes frames off the line at mid-bit, recording bytes and start times
   logic [7:0] rx_q[$];
   int st_q[$];
   int m_cyc = 0, m_t = 0, m_err = 0, m_k;
   logic m_on = 0;
   logic [7:0] m_b = 0;
   always @(negedge clk) begin
      m_cyc++;
      if (!reset) m_on = 0;
      else if (!m_on) begin
         if (tx === 1'b0) begin
            m_on = 1;
            m_t = 0;
            st_q.push_back(m_cyc);
         end
      end else begin
         m_t++;
         if (m_t % CPB == CPB / 2) begin
            m_k = m_t / CPB;
            if (m_k == 0 && tx !== 1'b0) m_err++;
            else if (m_k >= 1 && m_k <= 8) m_b[m_k-1] = tx;
            else if (m_k == 9) begin
               if (tx !== 1'b1) m_err++;
               rx_q.push_back(m_b);
               m_on = 0;
            end
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, i, bad, busy_n;
      logic acc;
      logic [9:0] line;
      int acc_at[8];
      int exp_burst[6] = '{0, 1, 2, 3, 4, 162};
      int exp_full[8] = '{0, 1, 2, 3, 4, 162, 322, 482};
      repeat (3) step();
      chk("reset tx", tx, 1);
      chk("reset ready", tx_ready, 1);
      chk("reset busy", tx_busy, 0);
      chk("reset level", tx_level, 0);
      chk("reset idle", tx_idle, 0);
      reset = 1;
      n = 0;
      while (!tx_idle && n < 400) begin step(); n++; end
      chk("idle after release", n, 256);
      rx_q.delete(); st_q.delete();
      tx_data = 8'hA5; tx_valid = 1;
      step();
      tx_valid = 0;
      chk("A5 tx on accept edge", tx, 1);
      chk("A5 level", tx_level, 1);
      chk("A5 idle drop", tx_idle, 0);
      step();
      line = 10'b1101001010;
      busy_n = 0;
      for (int k = 0; k < 10; k++) begin
         bad = 0;
         for (int c = 0; c < CPB; c++) begin
            if (tx !== line[k]) bad++;
            if (tx_busy) busy_n++;
            step();
         end
         chk($sformatf("A5 bit%0d bad samples", k), bad, 0);
      end
      chk("A5 busy cycles", busy_n, 160);
      chk("A5 busy after", tx_busy, 0);
      chk("A5 tx after", tx, 1);
      chk("A5 frames", rx_q.size(), 1);
      if (rx_q.size() > 0) chk("A5 decoded", rx_q[0], 8'hA5);
      rx_q.delete(); st_q.delete();
      i = 0; n = 0; tx_data = 8'h01; tx_valid = 1;
      while (i < 6 && n < 400) begin
         acc = tx_ready;
         step();
         if (acc) begin acc_at[i] = n; i++; tx_data = 8'(i + 1); end
         if (n == 4) begin
            chk("burst ready at full", tx_ready, 0);
            chk("burst level at full", tx_level, 4);
         end
         n++;
      end
      tx_valid = 0;
      for (int j = 0; j < 6; j++) chk($sformatf("burst accept %0d", j), acc_at[j], exp_burst[j]);
      n = 0;
      while (rx_q.size() < 6 && n < 2000) begin step(); n++; end
      chk("burst frames", rx_q.size(), 6);
      for (int j = 0; j < rx_q.size(); j++) chk($sformatf("burst byte %0d", j), rx_q[j], 8'(j + 1));
      for (int j = 1; j < st_q.size(); j++) chk($sformatf("burst gap %0d", j), st_q[j] - st_q[j-1], 160);
      chk("burst framing", m_err, 0);
      n = 0;
      while (tx_busy && n < 500) begin step(); n++; end
      tx_valid = 1; tx_data = 8'h3C; step();
      tx_data = 8'h11; step();
      tx_data = 8'h22; step();
      tx_valid = 0;
      repeat (70) step();
      chk("3C bit3", tx, 1);
      chk("3C queued", tx_level, 2);
      chk("3C busy", tx_busy, 1);
      #2 reset = 0;
      #1;
      chk("abort tx", tx, 1);
      chk("abort busy", tx_busy, 0);
      chk("abort level", tx_level, 0);
      chk("abort ready", tx_ready, 1);
      chk("abort idle", tx_idle, 0);
      step(); step();
      reset = 1;
      rx_q.delete(); st_q.delete();
      n = 0;
      while (!tx_idle && n < 400) begin step(); n++; end
      chk("abort idle delay", n, 256);
      chk("abort no frame", st_q.size(), 0);
      chk("abort tx high", tx, 1);
      i = 0; n = 0; tx_data = 8'h80; tx_valid = 1;
      while (i < 8 && n < 700) begin
         acc = tx_ready;
         step();
         if (acc) begin acc_at[i] = n; i++; tx_data = 8'h80 + 8'(i); end
         n++;
      end
      tx_valid = 0;
      for (int j = 0; j < 8; j++) chk($sformatf("full accept %0d", j), acc_at[j], exp_full[j]);
      n = 0;
      while (rx_q.size() < 8 && n < 2000) begin step(); n++; end
      chk("full frames", rx_q.size(), 8);
      for (int j = 0; j < rx_q.size(); j++) chk($sformatf("full byte %0d", j), rx_q[j], 8'h80 + 8'(j));
      for (int j = 1; j < st_q.size(); j++) chk($sformatf("full gap %0d", j), st_q[j] - st_q[j-1], 160);
      chk("full framing", m_err, 0);
      n = 0;
      while (tx_busy && n < 400) begin step(); n++; end
      n = 0;
      while (!tx_idle && n < 400) begin step(); n++; end
      chk("final idle delay", n, 256);
      while (n < 300) begin step(); n++; end
      chk("idle held", tx_idle, 1);
      tx_data = 8'h5A; tx_valid = 1;
      step();
      tx_valid = 0;
      chk("idle drop after push", tx_idle, 0);
      chk("tx high on accept", tx, 1);
      step();
      chk("tx falls after accept", tx, 0);
      chk("busy after accept", tx_busy, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises them onto the tx line: LSB first, one start bit, one stop bit.
- Contains its own bit-period counter, so it is independent of any shared baud tick.
- Sits opposite the existing UART receiver and feeds the host-facing serial pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200 rounded); must be >= 2.
- FIFO_DEPTH, 4, byte buffer entries; must be a power of 2 and >= 2.
- IDLE_BITS, 16, number of bit periods of inactivity before tx_idle asserts.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  FIFO can accept a byte (not full).
- tx  output  1  serial line, registered, idles high.
- tx_busy  output  1  a frame is in progress.
- tx_level  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.
- tx_idle  output  1  line has been idle for IDLE_BITS bit periods.

Behaviour:
- Reset (reset low) asynchronously forces:
  - tx=1, tx_busy=0, tx_idle=0, tx_level=0, tx_ready=1.
  - FIFO pointers cleared, FSM in IDLE, bit counter 0.
  - A reset mid-frame aborts the frame; no partial data resumes after release.
- Handshake:
  - A byte is accepted on a rising edge with tx_valid & tx_ready.
  - tx_ready = !full, combinational from the registered level.
  - A push while full is ignored, and the byte is not lost (ready was 0).
  - When a pop and a push happen in the same cycle, the level is unchanged.
- FIFO: show-ahead with wrap-bit pointers; order strictly preserved.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register, drive tx<=0, clear the bit counter and bit index, go to START.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then drive tx<=shift[0] and go to DATA.
  - DATA: each bit is held for CLKS_PER_BIT cycles. At each period end the register shifts right and the bit index increments. After bit index 7 completes, drive tx<=1 and go to STOP.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At period end, if the FIFO is non-empty, pop and go directly to START with tx<=0, with no extra idle cycle. Otherwise go to IDLE.
- Timing:
  - One frame is exactly 10*CLKS_PER_BIT cycles.
  - When the transmitter is idle and the FIFO empty, tx falls on the first rising edge after the accept edge (latency 1 cycle).
  - tx_busy = (state != IDLE).
- Bit counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at period end.
  - Runs only outside IDLE.
- Idle counter:
  - Counts clock cycles while in IDLE with the FIFO empty; saturates.
  - tx_idle=1 once the count reaches IDLE_BITS*CLKS_PER_BIT.
  - Cleared by any push or non-IDLE state; tx_idle falls the cycle after such a push.
- The tx output must be a flop, glitch-free.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t.
  - Localparams DATA_BITS=8 and STOP_BITS=1.
- Sub-module uart_tx_fifo, parameterised by width and depth:
  - Inputs push/pop; outputs head, full, empty, level.
  - Holds the only FIFO storage.
- FSM, bit counter and idle counter live in uart_tx.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=4, IDLE_BITS=16):
- Reset then hold: tx=1, tx_ready=1, tx_busy=0, tx_level=0. tx_idle rises exactly 256 cycles after reset release.
- Send 0xA5 once:
  - tx goes low 1 cycle after accept for 16 cycles.
  - Data bits then read 1,0,1,0,0,1,0,1, each held 16 cycles, followed by stop=1.
  - tx_busy is high for exactly 160 cycles.
- Burst 0x01..0x06 with tx_valid held:
  - 0x01..0x05 are accepted on consecutive cycles; tx_ready drops with tx_level=4.
  - 0x06 is accepted the cycle after the first frame's stop bit ends.
  - Six frames run back-to-back (960 cycles, tx never idle between them) in order 01..06.
- Assert reset during data bit 3 of 0x3C with 2 bytes queued:
  - tx=1, tx_busy=0, tx_level=0 immediately.
  - After release, no frame starts for 256+ cycles.
- FIFO full at a frame boundary with tx_valid held:
  - The pop and the reassertion of tx_ready occur on consecutive cycles.
  - The new byte appears exactly once and in order; no duplicates or drops over 8 frames.
- After the last stop bit: tx_idle=1 at 256 cycles. A push at cycle 300 drops tx_idle the next cycle and tx falls one cycle after the accept.
